jk_bank_arbiter: RTL and testbench
==================================

Name: jk_bank_arbiter

Overview:
- Shares one bank of NFF JK flip-flops between NREQ requesters.
- Each requester issues single-bit JK commands: address, j and k, over a valid/ready handshake.
- A round-robin arbiter accepts at most one command per cycle and applies standard JK semantics to the addressed bit.
- Sits between control logic and any status/flag register built on the team's JK flip-flop cells.

Parameters:
- NREQ, 4: number of requesters (2..8).
- NFF, 8: number of JK flip-flops in the bank (2..256).
- AW, 3: address width; must satisfy 2**AW >= NFF.
- GW, 2: grant-id width; must satisfy 2**GW >= NREQ.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- hold_en  input  1  when 1, no command is accepted (all req_ready = 0).
- req_valid  input  NREQ  per-requester command valid.
- req_ready  output  NREQ  per-requester accept. Combinational; at most one bit high.
- req_addr  input  NREQ*AW  target bit index. Requester i uses bits [i*AW +: AW].
- req_j  input  NREQ  J input per requester.
- req_k  input  NREQ  K input per requester.
- q  output  NFF  flip-flop bank state.
- qbar  output  NFF  always the bitwise complement of q.
- grant_valid  output  1  registered; 1 for one cycle after an accept.
- grant_id  output  GW  registered; index of the requester accepted in the previous cycle.
- err_addr  output  1  registered; 1 for one cycle after accepting a command with addr >= NFF.

Behaviour:
- Reset (rst = 0, asynchronous): q = 0, qbar = all ones, rr_ptr = 0, grant_valid = 0, grant_id = 0, err_addr = 0.
- Outputs are already at these values during reset, independent of clk.
- Reset mid-command: the command is discarded. After release, the requester must still hold valid to be re-accepted.
- Arbitration (combinational):
  - Winner = first i with req_valid[i] = 1, scanning rr_ptr, rr_ptr+1, …, wrapping modulo NREQ.
  - req_ready[winner] = 1 unless hold_en = 1 or rst = 0. All other ready bits are 0.
  - With no valid requests, all ready bits are 0.
- Accept = req_valid[i] & req_ready[i] at a rising edge. On accept:
  - rr_ptr <= (winner + 1) mod NREQ. rr_ptr is unchanged when nothing is accepted.
  - The addressed bit updates at the same edge. New q is visible after that edge (latency 1 cycle).
  - grant_valid <= 1 and grant_id <= winner at the same edge; otherwise grant_valid <= 0 and grant_id holds its value.
- JK semantics on the addressed bit, by j,k:
  - 00: hold.
  - 01: clear to 0.
  - 10: set to 1.
  - 11: toggle.
  - All unaddressed bits hold.
- Out-of-range address (addr >= NFF): the command is accepted (ready asserted, pointer advances), q is unchanged, and err_addr pulses for 1 cycle.
- Requester obligations: keep valid, addr, j and k stable until accepted. Dropping valid before ready is permitted and has no effect.
- Throughput: 1 command per cycle. Back-to-back commands from different requesters to the same bit apply in grant order.
- Fairness: any continuously valid requester is accepted within NREQ cycles while hold_en = 0.
- hold_en = 1: ready is all zero, q holds, rr_ptr holds, grant_valid <= 0.

Optional Feature:
- Macro: JK_BANK_ARBITER_STATS_EN.
- Defined: adds output toggle_cnt [15:0], reset to 0.
  - Increments by 1 at each accepted in-range command whose application changes the addressed bit (any j,k).
  - Saturates at 16'hFFFF.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then release; NREQ=4, NFF=8 → q = 8'h00, qbar = 8'hFF, grant_valid = 0.
- After release, no stimulus → all outputs hold at reset values.
- Req0 sets bit3 (j=1,k=0); next cycle req0 toggles bit3 (j=1,k=1) → q = 8'h08, then 8'h00. grant_id = 0 both times; qbar always ~q.
- Req0..3 all valid continuously, each with addr = its own index and j=k=1 → grants in order 0,1,2,3,0; each bit toggles once per 4 cycles.
- Req2 with addr = 9 → req_ready[2] = 1, q unchanged, err_addr = 1 for exactly one cycle.
- Assert hold_en for 3 cycles with req1 valid → req_ready = 0 throughout; accepted on the first cycle after hold_en falls.
- Drive rst = 0 asynchronously mid-stream with q = 8'hA5 → q = 0 immediately without a clock edge, rr_ptr = 0. With STATS_EN, toggle_cnt = 0.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a bank of JK flip-flops between several requesters.
// Optional JK_BANK_ARBITER_STATS_EN adds a saturating count of accepted commands that changed a bit.
module jk_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int NFF  = 8,
  parameter int AW   = 3,
  parameter int GW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold_en,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]    req_j,
  input  logic [NREQ-1:0]    req_k,
  output logic [NFF-1:0]     q,
  output logic [NFF-1:0]     qbar,
  output logic               grant_valid,
  output logic [GW-1:0]      grant_id,
  output logic               err_addr
`ifdef JK_BANK_ARBITER_STATS_EN
  ,
  output logic [15:0]        toggle_cnt
`endif
);

  if ((1 << AW) < NFF || (1 << GW) < NREQ) begin : g_bad_params
    $error("jk_bank_arbiter: AW or GW too narrow for NFF/NREQ");
  end

  logic [GW-1:0]  rr_ptr;
  logic [GW-1:0]  winner;
  logic           found;
  int unsigned    idx;
  logic [AW-1:0]  w_addr;
  logic           w_j;
  logic           w_k;
  logic           in_range;
  logic           accept;
  logic [NFF-1:0] q_next;

  // Scan from rr_ptr upward, wrapping, and take the first valid requester.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned o = 0; o < NREQ; o++) begin
      idx = (32'(rr_ptr) + o) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found && !hold_en && rst) req_ready[winner] = 1'b1;
    accept = |(req_valid & req_ready);

    w_addr = '0;
    w_j    = 1'b0;
    w_k    = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (GW'(i) == winner) begin
        w_addr = req_addr[i*AW +: AW];
        w_j    = req_j[i];
        w_k    = req_k[i];
      end
    end
    in_range = int'(w_addr) < NFF;

    q_next = q;
    for (int unsigned b = 0; b < NFF; b++) begin
      if (accept && in_range && w_addr == AW'(b)) begin
        case ({w_j, w_k})
          2'b01:   q_next[b] = 1'b0;
          2'b10:   q_next[b] = 1'b1;
          2'b11:   q_next[b] = ~q[b];
          default: q_next[b] = q[b];
        endcase
      end
    end
  end

  assign qbar = ~q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q           <= '0;
      rr_ptr      <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      err_addr    <= 1'b0;
    end else begin
      q           <= q_next;
      grant_valid <= accept;
      err_addr    <= accept & ~in_range;
      if (accept) begin
        rr_ptr   <= GW'((32'(winner) + 1) % NREQ);
        grant_id <= winner;
      end
    end
  end

`ifdef JK_BANK_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toggle_cnt <= '0;
    end else if (q_next != q && toggle_cnt != '1) begin
      toggle_cnt <= toggle_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration and JK rules.
module tb_jk_bank_arbiter;
  localparam int NREQ = 4;
  localparam int NFF  = 8;
  localparam int AW   = 4;
  localparam int GW   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               hold_en = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0]    req_j = '0;
  logic [NREQ-1:0]    req_k = '0;
  logic [NFF-1:0]     q;
  logic [NFF-1:0]     qbar;
  logic               grant_valid;
  logic [GW-1:0]      grant_id;
  logic               err_addr;
`ifdef JK_BANK_ARBITER_STATS_EN
  logic [15:0]        toggle_cnt;
`endif

  jk_bank_arbiter #(.NREQ(NREQ), .NFF(NFF), .AW(AW), .GW(GW)) dut (
    .clk(clk), .rst(rst), .hold_en(hold_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_j(req_j), .req_k(req_k), .q(q), .qbar(qbar),
    .grant_valid(grant_valid), .grant_id(grant_id), .err_addr(err_addr)
`ifdef JK_BANK_ARBITER_STATS_EN
    , .toggle_cnt(toggle_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit mq[NFF];
  int mptr;
  bit mgv;
  int mgid;
  bit merr;
  int mcnt;
  int last_win;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NFF-1:0] mq_vec();
    logic [NFF-1:0] v;
    for (int b = 0; b < NFF; b++) v[b] = mq[b];
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NFF; b++) mq[b] = 1'b0;
    mptr = 0; mgv = 0; mgid = 0; merr = 0; mcnt = 0;
  endtask

  function automatic int model_winner();
    int i;
    if (hold_en || !rst) return -1;
    for (int o = 0; o < NREQ; o++) begin
      i = (mptr + o) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_apply(input int win);
    int a;
    bit old, nw, j, k;
    if (win < 0) begin
      mgv = 0; merr = 0;
      return;
    end
    a = int'(req_addr[win*AW +: AW]);
    mgv = 1; mgid = win; mptr = (win + 1) % NREQ;
    merr = (a >= NFF);
    if (a < NFF) begin
      old = mq[a]; j = req_j[win]; k = req_k[win];
      nw = (j && k) ? !old : j ? 1'b1 : k ? 1'b0 : old;
      if (nw != old && mcnt < 65535) mcnt++;
      mq[a] = nw;
    end
  endtask

  // Called just after inputs are driven (shortly after a falling edge); ends after the next falling edge.
  task automatic run_cycle();
    int win;
    logic [NREQ-1:0] er;
    logic [NFF-1:0] ev;
    #1;
    win = model_winner();
    er = '0;
    if (win >= 0) er[win] = 1'b1;
    check("ready", req_ready, er);
    model_apply(win);
    last_win = win;
    @(posedge clk);
    @(negedge clk);
    ev = mq_vec();
    check("q", q, ev);
    ev = ~mq_vec();
    check("qbar", qbar, ev);
    check("grant_valid", grant_valid, mgv);
    check("grant_id", grant_id, mgid);
    check("err_addr", err_addr, merr);
`ifdef JK_BANK_ARBITER_STATS_EN
    check("toggle_cnt", toggle_cnt, mcnt);
`endif
  endtask

  task automatic issue(input int r, input int a, input bit j, input bit k);
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_addr[r*AW +: AW] = AW'(a);
    req_j[r] = j;
    req_k[r] = k;
    run_cycle();
    req_valid = '0;
  endtask

  initial begin
    model_reset();
    last_win = -1;

    // Reset held: outputs at reset values, no ready even with requests pending.
    req_valid = '1;
    #2;
    check("rst_q", q, 8'h00);
    check("rst_qbar", qbar, 8'hFF);
    check("rst_gv", grant_valid, 1'b0);
    check("rst_gid", grant_id, 2'd0);
    check("rst_err", err_addr, 1'b0);
    check("rst_ready", req_ready, 4'h0);
    @(posedge clk);
    @(negedge clk);
    check("rst_q_clk", q, 8'h00);
    req_valid = '0;
    rst = 1'b1;

    for (int c = 0; c < 3; c++) run_cycle();

    // Set then toggle bit 3 from requester 0.
    issue(0, 3, 1'b1, 1'b0);
    check("set_b3", q, 8'h08);
    check("set_gid", grant_id, 2'd0);
    issue(0, 3, 1'b1, 1'b1);
    check("tog_b3", q, 8'h00);
    check("tog_gid", grant_id, 2'd0);

    // Reset pulse to bring the pointer back to 0, then all four toggle their own bit.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
    req_valid = '1;
    req_j = '1;
    req_k = '1;
    for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = AW'(i);
    for (int c = 0; c < 5; c++) begin
      run_cycle();
      check("rr_order", grant_id, 32'(c % NREQ));
    end
    check("rr_q", q, 8'h0E);
    req_valid = '0;

    // Out-of-range address from requester 2.
    issue(2, 9, 1'b1, 1'b1);
    check("oor_err", err_addr, 1'b1);
    check("oor_q", q, 8'h0E);
    run_cycle();
    check("oor_err_clr", err_addr, 1'b0);

    // hold_en blocks requester 1 for three cycles.
    hold_en = 1'b1;
    req_valid[1] = 1'b1;
    req_addr[1*AW +: AW] = AW'(5);
    req_j[1] = 1'b1;
    req_k[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      check("hold_gv", grant_valid, 1'b0);
    end
    hold_en = 1'b0;
    run_cycle();
    check("hold_acc_gv", grant_valid, 1'b1);
    check("hold_acc_gid", grant_id, 2'd1);
    req_valid = '0;

    // Build 8'hA5, then assert reset between clock edges.
    for (int b = 0; b < NFF; b++)
      issue(0, b, ((8'hA5 >> b) & 1) != 0, ((8'hA5 >> b) & 1) == 0);
    check("a5_q", q, 8'hA5);
    req_valid[0] = 1'b1;
    req_addr[0 +: AW] = AW'(1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("arst_q", q, 8'h00);
    check("arst_qbar", qbar, 8'hFF);
    check("arst_gv", grant_valid, 1'b0);
    check("arst_ready", req_ready, 4'h0);
`ifdef JK_BANK_ARBITER_STATS_EN
    check("arst_cnt", toggle_cnt, 16'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    check("arst_q_clk", q, 8'h00);
    rst = 1'b1;
    req_valid = '1;
    run_cycle();
    check("arst_ptr", grant_id, 2'd0);

    // Randomized traffic with occasional hold and withdrawn requests.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || i == last_win) begin
          req_valid[i] = 1'($urandom % 2);
          req_addr[i*AW +: AW] = AW'($urandom_range(0, 11));
          req_j[i] = 1'($urandom % 2);
          req_k[i] = 1'($urandom % 2);
        end else if ($urandom % 8 == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      hold_en = ($urandom % 10) == 0;
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
